cpu_mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's single memory port. It accepts the CPU's address, write strobe and write data, and returns read data one cycle later. Internally it holds a byte-addressed little-endian RAM plus a small memory-mapped I/O page (cycle counter, LED register, fault status). It replaces the bare memory instance on the CPU top and keeps the same port contract, so the control unit's wait-state timing is unchanged.

---
 rtl/cpu_mem_responder.sv | 105 ++++++++++
 tb/tb_cpu_mem_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Single-port memory responder for the multicycle CPU: little-endian byte RAM
// with wrapping word access plus a 256-byte MMIO page (CYCLES, LED, STATUS).
module cpu_mem_responder #(
   parameter int          DEPTH_BYTES = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        wr,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   output logic [31:0] led,
   output logic        fault
);

   localparam int AW = $clog2(DEPTH_BYTES);

   localparam logic [7:0] OFF_CYCLES = 8'h00;
   localparam logic [7:0] OFF_LED    = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h08;

   logic [7:0]    mem [DEPTH_BYTES];

   logic [31:0]   dataout_q, dataout_d;
   logic [31:0]   cycles_q,  cycles_d;
   logic [31:0]   led_q,     led_d;
   logic          fault_q,   fault_d;

   logic          is_mmio;
   logic [7:0]    off;
   logic [AW-1:0] idx;
   logic          bad_mmio;
   logic [31:0]   ram_word;
   logic [31:0]   mmio_word;

   assign is_mmio = (address[31:8] == MMIO_BASE[31:8]);
   assign off     = address[7:0];
   assign idx     = address[AW-1:0];

   // Misaligned offsets never match an exact register offset, so they fault too.
   assign bad_mmio = is_mmio &&
                     (off != OFF_CYCLES) && (off != OFF_LED) && (off != OFF_STATUS);

   // Index arithmetic is AW bits wide, so words wrap past the top of RAM.
   always_comb begin
      ram_word = '0;
      for (int k = 0; k < 4; k++) begin
         ram_word[8*k +: 8] = mem[idx + AW'(k)];
      end
   end

   always_comb begin
      mmio_word = '0;
      case (off)
         OFF_CYCLES: mmio_word = cycles_q;
         OFF_LED:    mmio_word = led_q;
         OFF_STATUS: mmio_word = {31'b0, fault_q};
         default:    mmio_word = '0;
      endcase
   end

   always_comb begin
      dataout_d = is_mmio ? mmio_word : ram_word;

      cycles_d = cycles_q + 32'd1;
      if (is_mmio && wr && (off == OFF_CYCLES)) cycles_d = datain;

      led_d = led_q;
      if (is_mmio && wr && (off == OFF_LED)) led_d = datain;

      // A bad access is applied last so it overrides a same-cycle clear.
      fault_d = fault_q;
      if (is_mmio && wr && (off == OFF_STATUS)) fault_d = 1'b0;
      if (bad_mmio) fault_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dataout_q <= '0;
         cycles_q  <= '0;
         led_q     <= '0;
         fault_q   <= 1'b0;
      end else begin
         dataout_q <= dataout_d;
         cycles_q  <= cycles_d;
         led_q     <= led_d;
         fault_q   <= fault_d;
      end
   end

   // RAM has no reset; only the write is gated by it.
   always_ff @(posedge clk) begin
      if (!reset && wr && !is_mmio) begin
         for (int k = 0; k < 4; k++) begin
            mem[idx + AW'(k)] <= datain[8*k +: 8];
         end
      end
   end

   assign dataout = dataout_q;
   assign led     = led_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: RAM, wrap, read-before-write,
// cycle counter, LED/fault MMIO and reset behaviour.
module tb_cpu_mem_responder;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic        wr;
   logic [31:0] datain;
   logic [31:0] dataout;
   logic [31:0] led;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   cpu_mem_responder #(.DEPTH_BYTES(256), .MMIO_BASE(32'hFFFF_FF00)) dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .wr      (wr),
      .datain  (datain),
      .dataout (dataout),
      .led     (led),
      .fault   (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one access, take the edge, then settle before sampling.
   task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] d);
      address = a;
      wr      = w;
      datain  = d;
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      acc(32'h0, 1'b0, 32'h0);
      acc(32'h0, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h0) begin n_bad++; $display("FAIL reset_dataout got %h want %h", dataout, 32'h0); end
      n_cmp++; if (led !== 32'h0) begin n_bad++; $display("FAIL reset_led got %h want %h", led, 32'h0); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
      reset = 1'b0;
   endtask

   task automatic test_ram();
      acc(32'h14, 1'b1, 32'h0000_0000);
      acc(32'h10, 1'b1, 32'hDEAD_BEEF);
      acc(32'h10, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_rd got %h want %h", dataout, 32'hDEAD_BEEF); end
      acc(32'h11, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h00DE_ADBE) begin n_bad++; $display("FAIL ram_unaligned got %h want %h", dataout, 32'h00DE_ADBE); end
      acc(32'h110, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_alias got %h want %h", dataout, 32'hDEAD_BEEF); end
   endtask

   task automatic test_wrap();
      acc(32'hFE, 1'b1, 32'h1122_3344);
      acc(32'h00, 1'b0, 32'h0);
      n_cmp++; if (dataout[15:0] !== 16'h1122) begin n_bad++; $display("FAIL wrap_low got %h want %h", dataout[15:0], 16'h1122); end
      acc(32'hFE, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h1122_3344) begin n_bad++; $display("FAIL wrap_word got %h want %h", dataout, 32'h1122_3344); end
   endtask

   task automatic test_back_to_back();
      acc(32'h20, 1'b1, 32'h1);
      acc(32'h20, 1'b1, 32'h2);
      n_cmp++; if (dataout !== 32'h1) begin n_bad++; $display("FAIL rbw_old got %h want %h", dataout, 32'h1); end
      acc(32'h20, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h2) begin n_bad++; $display("FAIL rbw_new got %h want %h", dataout, 32'h2); end
   endtask

   task automatic test_counter();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) acc(32'h40, 1'b0, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) acc(32'h40, 1'b0, 32'h0);
      acc(32'hFFFF_FF00, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'd4) begin n_bad++; $display("FAIL cycles_after_reset got %0d want 4", dataout); end
      acc(32'hFFFF_FF00, 1'b1, 32'hFFFF_FFFF);
      n_cmp++; if (dataout !== 32'd5) begin n_bad++; $display("FAIL cycles_wr_old got %0d want 5", dataout); end
      acc(32'h40, 1'b0, 32'h0);
      acc(32'hFFFF_FF00, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h0) begin n_bad++; $display("FAIL cycles_wrap got %h want %h", dataout, 32'h0); end
   endtask

   task automatic test_led_fault();
      acc(32'hFFFF_FF04, 1'b1, 32'hA5);
      n_cmp++; if (led !== 32'hA5) begin n_bad++; $display("FAIL led_wr got %h want %h", led, 32'hA5); end
      acc(32'hFFFF_FF04, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'hA5) begin n_bad++; $display("FAIL led_rd got %h want %h", dataout, 32'hA5); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_idle got %b want 0", fault); end
      acc(32'hFFFF_FF0C, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h0) begin n_bad++; $display("FAIL bad_rd_data got %h want %h", dataout, 32'h0); end
      n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL bad_rd_fault got %b want 1", fault); end
      acc(32'h40, 1'b0, 32'h0);
      n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky got %b want 1", fault); end
      acc(32'hFFFF_FF08, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'h1) begin n_bad++; $display("FAIL status_rd got %h want %h", dataout, 32'h1); end
      acc(32'hFFFF_FF08, 1'b1, 32'h0);
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL status_clr got %b want 0", fault); end
      acc(32'hFFFF_FF05, 1'b1, 32'h33);
      n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL misalign_fault got %b want 1", fault); end
      n_cmp++; if (led !== 32'hA5) begin n_bad++; $display("FAIL misalign_led got %h want %h", led, 32'hA5); end
   endtask

   task automatic test_reset_mid();
      acc(32'h30, 1'b1, 32'hCAFE_0001);
      acc(32'h30, 1'b0, 32'h0);
      reset = 1'b1;
      acc(32'h30, 1'b1, 32'h77);
      n_cmp++; if (dataout !== 32'h0) begin n_bad++; $display("FAIL rst_mid_dataout got %h want %h", dataout, 32'h0); end
      acc(32'hFFFF_FF04, 1'b1, 32'h5);
      n_cmp++; if (led !== 32'h0) begin n_bad++; $display("FAIL rst_mid_led got %h want %h", led, 32'h0); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_mid_fault got %b want 0", fault); end
      reset = 1'b0;
      acc(32'h30, 1'b0, 32'h0);
      n_cmp++; if (dataout !== 32'hCAFE_0001) begin n_bad++; $display("FAIL rst_mid_ram got %h want %h", dataout, 32'hCAFE_0001); end
      n_cmp++; if (led !== 32'h0) begin n_bad++; $display("FAIL rst_mid_led_after got %h want %h", led, 32'h0); end
   endtask

   initial begin
      reset   = 1'b1;
      address = '0;
      wr      = 1'b0;
      datain  = '0;
      test_reset();
      test_ram();
      test_wrap();
      test_back_to_back();
      test_counter();
      test_led_fault();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
